hs_spi_arbiter_m: RTL and testbench
===================================

// Module: hs_spi_arbiter_m
// PURPOSE
//   Shares one hs_spi_master_m link between N_REQ requesters, one transfer in flight.
//   Round-robin grant picks a requester, its word goes to the master's load/data_in, and
//   the received word returns to that requester only. Timeout guards a missing valid.
//   Sits between client logic and the master, in the master's clk domain.
// PARAMETERS
//   N_REQ   4    number of requesters (>=2)
//   DW      32   word width; equals master DW
//   TMO     255  max cycles from load accepted to spi_valid before timeout (>=1)
// PORTS
//   clk          in   1          system clock; same clk as the master
//   rst          in   1          synchronous reset, active-low (0 = reset)
//   req_valid    in   N_REQ      requester i has a word to send
//   req_ready    out  N_REQ      one-hot; word i accepted this cycle
//   req_data     in   N_REQ*DW   packed words; slice i = [i*DW +: DW]
//   rsp_valid    out  N_REQ      one-hot, 1-cycle pulse; rsp_data belongs to requester i
//   rsp_data     out  DW         received word, shared bus
//   rsp_err      out  1          qualifies rsp_valid: 1 = timeout, rsp_data = '0
//   spi_load     out  1          to master load
//   spi_ready    in   1          from master ready (input buffer empty)
//   spi_data_in  out  DW         to master data_in
//   spi_valid    in   1          from master valid (1-cycle pulse)
//   spi_data_out in   DW         from master data_out
//   busy         out  1          state != IDLE
// BEHAVIOUR
//   Reset (rst=0 at clk edge): state IDLE, rr pointer 0, all outputs 0, TMO counter 0.
//   States: IDLE -> LOAD -> WAIT -> RESP -> IDLE.
//   IDLE: if any req_valid, grant = first set bit at/after rr pointer (wrapping);
//     latch grant index and req_data slice; pulse req_ready[grant] that cycle; -> LOAD.
//   LOAD: drive spi_data_in = latched word; spi_load=1 while spi_ready=0; in the cycle
//     spi_ready=1 and spi_load=1 the word is taken; clear TMO counter; -> WAIT.
//   WAIT: count cycles. spi_valid=1 -> latch spi_data_out, -> RESP. Counter==TMO with
//     no valid -> rsp_err=1, data '0, -> RESP. spi_valid on the TMO cycle wins (no err).
//   RESP: rsp_valid[grant]=1 one cycle; rr pointer = grant+1 mod N_REQ; -> IDLE.
//   Throughput: one transfer at a time; a new grant earliest the cycle after RESP.
//   spi_valid outside WAIT is ignored (stale or late response); no rsp_valid raised.
//   req_valid dropped after grant has no effect; transaction completes.
//   spi_data_in holds latched word from LOAD until next grant; master reads it only on load.
//   Reset mid-operation: abandons transfer, no rsp_valid; master is reset by the same
//     system and is not flushed by this block.
//   Counter width $clog2(TMO+1); saturating, never wraps.
// STRUCTURE
//   hs_spi_pkg: arb_state_t {arbIDLE, arbLOAD, arbWAIT, arbRESP}; TMO default constant.
//   Sub-module rr_arbiter_m #(N): req vector + pointer -> one-hot grant + index,
//     combinational, reused by other shared-resource arbiters. FSM, latches and
//     counter stay in hs_spi_arbiter_m.
// TESTING (bench instantiates hs_spi_master_m DW=32 SPI_W=4 + hs_spi_slave_m loopback)
//   Single req: req_valid=4'b0001, data 0xA5A5_0001 -> req_ready[0] 1 cycle,
//     slave receives 0xA5A5_0001, rsp_valid=4'b0001 with slave's preloaded word.
//   All four held valid from rr=0 -> grants 0,1,2,3,0 in order; each rsp routed only to
//     its own index; rsp_data matches per-requester slave word.
//   Backpressure: hold spi_ready=0 for 20 cycles in LOAD -> spi_load held high,
//     spi_data_in stable, exactly one load handshake.
//   Timeout TMO=8, master stubbed never pulsing valid -> rsp_valid with rsp_err=1,
//     rsp_data=0 exactly 8 cycles after load; next req proceeds normally.
//   Stray spi_valid in IDLE -> no rsp_valid, state unchanged.
//   rst=0 asserted in WAIT -> next cycle busy=0, req_ready/rsp_valid=0, rr pointer 0.

Source files
------------

// File: rtl/hs_spi_pkg.sv
// Shared types for the SPI link arbiter: FSM encoding and default timeout.
package hs_spi_pkg;

  typedef enum logic [1:0] {arbIDLE, arbLOAD, arbWAIT, arbRESP} arb_state_t;

  localparam int TMO_DEF = 255;

endpackage

// File: rtl/rr_arbiter_m.sv
// Combinational round-robin picker: first set request at/after ptr, wrapping.
module rr_arbiter_m #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan from the farthest offset down so the nearest request overwrites last.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) idx = IW'((int'(ptr) + i) % N);
    end
  end

  assign any   = |req;
  assign grant = any ? ({{(N-1){1'b0}}, 1'b1} << idx) : '0;

endmodule

// File: rtl/hs_spi_arbiter_m.sv
// Shares one hs_spi_master_m link between N_REQ requesters; one transfer in flight,
// round-robin grant, response routed back to the granted requester, timeout on no valid.
module hs_spi_arbiter_m
  import hs_spi_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DW    = 32,
  parameter int TMO   = TMO_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]       rsp_data,
  output logic                rsp_err,
  output logic                spi_load,
  input  logic                spi_ready,
  output logic [DW-1:0]       spi_data_in,
  input  logic                spi_valid,
  input  logic [DW-1:0]       spi_data_out,
  output logic                busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TMO + 1);

  arb_state_t        state_q, state_d;
  logic [IW-1:0]     gidx_q, rr_q, arb_idx;
  logic [N_REQ-1:0]  arb_grant;
  logic              arb_any;
  logic [DW-1:0]     word_q, rdata_q;
  logic              err_q;
  logic [CW-1:0]     cnt_q, cnt_nxt;
  logic              tmo_hit;

  rr_arbiter_m #(.N(N_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (rr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // Saturating count; timeout fires on the WAIT cycle that brings it to TMO.
  assign cnt_nxt = (cnt_q == CW'(TMO)) ? cnt_q : cnt_q + 1'b1;
  assign tmo_hit = (cnt_nxt == CW'(TMO));

  always_ff @(posedge clk) begin
    if (!rst) state_q <= arbIDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      arbIDLE: if (arb_any) state_d = arbLOAD;
      arbLOAD: if (spi_ready) state_d = arbWAIT;
      arbWAIT: if (spi_valid || tmo_hit) state_d = arbRESP;
      arbRESP: state_d = arbIDLE;
      default: state_d = arbIDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      gidx_q  <= '0;
      rr_q    <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        arbIDLE: if (arb_any) begin
          gidx_q <= arb_idx;
          word_q <= req_data[arb_idx*DW +: DW];
        end
        arbLOAD: if (spi_ready) cnt_q <= '0;
        arbWAIT: begin
          cnt_q <= cnt_nxt;
          if (spi_valid) begin
            rdata_q <= spi_data_out;
            err_q   <= 1'b0;
          end else if (tmo_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        arbRESP: rr_q <= (gidx_q == IW'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
        default: ;
      endcase
    end
  end

  // req_ready is combinational on req_valid, so hold it low while reset is applied.
  assign req_ready   = (rst && state_q == arbIDLE) ? arb_grant : '0;
  assign rsp_valid   = (state_q == arbRESP) ? ({{(N_REQ-1){1'b0}}, 1'b1} << gidx_q) : '0;
  assign rsp_err     = (state_q == arbRESP) && err_q;
  assign rsp_data    = rdata_q;
  assign spi_load    = (state_q == arbLOAD);
  assign spi_data_in = word_q;
  assign busy        = (state_q != arbIDLE);

endmodule

// File: tb/tb_hs_spi_arbiter_m.sv
// Directed bench for hs_spi_arbiter_m with a behavioural SPI master/slave stub.
module tb_hs_spi_arbiter_m;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid, req_ready, rsp_valid;
  logic [N*DW-1:0] req_data;
  logic [DW-1:0] rsp_data, spi_data_in;
  logic [DW-1:0] spi_data_out = '0;
  logic          rsp_err, spi_load, spi_ready, busy;
  logic          spi_valid = 1'b0;

  hs_spi_arbiter_m #(.N_REQ(N), .DW(DW), .TMO(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_data     (req_data),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .spi_load     (spi_load),
    .spi_ready    (spi_ready),
    .spi_data_in  (spi_data_in),
    .spi_valid    (spi_valid),
    .spi_data_out (spi_data_out),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Master+slave stand-in: captures the loaded word, answers slave_word dly cycles
  // after the handshake cycle (dly=0: never answers).
  logic [DW-1:0] slave_word, slave_rx = '0;
  logic          force_valid;
  int            dly, cd = 0, hs_cyc = 0, hs_count = 0;

  always @(posedge clk) begin
    spi_valid <= 1'b0;
    if (force_valid) begin
      spi_valid    <= 1'b1;
      spi_data_out <= 32'hDEAD_BEEF;
    end
    if (cd == 1) begin
      spi_valid    <= 1'b1;
      spi_data_out <= slave_word;
    end
    if (cd > 0) cd <= cd - 1;
    if (spi_load && spi_ready && rst) begin
      slave_rx <= spi_data_in;
      hs_cyc   <= cyc;
      hs_count <= hs_count + 1;
      if (dly == 1) begin
        spi_valid    <= 1'b1;
        spi_data_out <= slave_word;
      end else if (dly > 1) cd <= dly - 1;
    end
    if (!rst) cd <= 0;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] mk(input logic [DW-1:0] b);
    logic [N*DW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = b ^ 32'(i + 1);
    return r;
  endfunction

  typedef struct {
    logic [N-1:0]  v;
    logic [DW-1:0] base;
    logic [DW-1:0] w;
    int            dly;
    int            g;
    logic          err;
  } vec_t;

  vec_t tbl[9];

  task automatic wait_rsp(output bit got);
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("rsp_wait_expired", 64'(rsp_valid), 64'(1));
  endtask

  task automatic do_txn(input vec_t t);
    bit got;
    @(negedge clk);
    req_valid  = t.v;
    req_data   = mk(t.base);
    slave_word = t.w;
    dly        = t.dly;
    #1;
    chk("req_ready", 64'(req_ready), 64'(4'b0001 << t.g));
    @(negedge clk);
    req_valid = '0;
    wait_rsp(got);
    if (got) begin
      chk("rsp_valid", 64'(rsp_valid), 64'(4'b0001 << t.g));
      chk("rsp_err", 64'(rsp_err), 64'(t.err));
      chk("rsp_data", 64'(rsp_data), t.err ? 64'(0) : 64'(t.w));
      chk("slave_rx", 64'(slave_rx), 64'(t.base ^ 32'(t.g + 1)));
      chk("latency", 64'(cyc - hs_cyc), 64'((t.err ? TMO : t.dly) + 1));
      @(negedge clk);
      chk("rsp_pulse", 64'(rsp_valid), 64'(0));
      chk("idle_after", 64'(busy), 64'(0));
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit   got;
    bit   held;
    int   hs0;
    tbl[0] = '{4'b0001, 32'hA5A5_0000, 32'h1234_5678, 3, 0, 1'b0};
    tbl[1] = '{4'b1111, 32'h1111_0000, 32'h0BAD_0001, 1, 1, 1'b0};
    tbl[2] = '{4'b1111, 32'h2222_0000, 32'h0BAD_0002, 5, 2, 1'b0};
    tbl[3] = '{4'b1111, 32'h3333_0000, 32'h0BAD_0003, 2, 3, 1'b0};
    tbl[4] = '{4'b1111, 32'h4444_0000, 32'h0BAD_0004, 4, 0, 1'b0};
    tbl[5] = '{4'b0100, 32'h5555_0000, 32'h7777_8888, TMO, 2, 1'b0};
    tbl[6] = '{4'b0011, 32'h6666_0000, 32'h9999_AAAA, 0, 0, 1'b1};
    tbl[7] = '{4'b1001, 32'h7777_0000, 32'hFEED_0007, 2, 3, 1'b0};
    tbl[8] = '{4'b0110, 32'h8888_0000, 32'hFEED_0008, TMO + 1, 1, 1'b1};

    rst = 1'b0; req_valid = 4'b1111; req_data = '0; spi_ready = 1'b1;
    force_valid = 1'b0; dly = 0; slave_word = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_spi_load", 64'(spi_load), 64'(0));
    chk("rst_spi_data_in", 64'(spi_data_in), 64'(0));
    chk("rst_rsp_err", 64'(rsp_err), 64'(0));
    req_valid = '0;
    rst = 1'b1;

    foreach (tbl[i]) do_txn(tbl[i]);

    // Stray valid while idle must not produce a response.
    @(negedge clk);
    hs0 = hs_count;
    force_valid = 1'b1;
    @(negedge clk);
    force_valid = 1'b0;
    chk("stray_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("stray_busy", 64'(busy), 64'(0));
    @(negedge clk);
    chk("stray_rsp_valid2", 64'(rsp_valid), 64'(0));
    chk("stray_busy2", 64'(busy), 64'(0));
    chk("stray_no_load", 64'(hs_count - hs0), 64'(0));

    // Backpressure: master not ready for 20 cycles in LOAD (rr=2, only req 1 -> wraps).
    @(negedge clk);
    spi_ready = 1'b0; req_valid = 4'b0010; req_data = mk(32'hB0B0_0000);
    slave_word = 32'hCAFE_F00D; dly = 2; hs0 = hs_count;
    #1;
    chk("bp_req_ready", 64'(req_ready), 64'(4'b0010));
    @(negedge clk);
    req_valid = '0;
    held = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (!spi_load || spi_data_in !== 32'hB0B0_0002) held = 1'b0;
      @(negedge clk);
    end
    chk("bp_load_held", 64'(held), 64'(1));
    spi_ready = 1'b1;
    wait_rsp(got);
    if (got) begin
      chk("bp_rsp_valid", 64'(rsp_valid), 64'(4'b0010));
      chk("bp_rsp_data", 64'(rsp_data), 64'(32'hCAFE_F00D));
      chk("bp_one_handshake", 64'(hs_count - hs0), 64'(1));
    end

    // Reset while waiting on the master: rr=2 here, so grant 2 first.
    @(negedge clk);
    req_valid = 4'b1111; req_data = mk(32'hC0C0_0000); dly = 0;
    #1;
    chk("rw_req_ready", 64'(req_ready), 64'(4'b0100));
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (busy && !spi_load) begin
        got = 1'b1;
        break;
      end
    end
    chk("rw_reached_wait", 64'(got), 64'(1));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rw_busy", 64'(busy), 64'(0));
    chk("rw_req_ready", 64'(req_ready), 64'(0));
    chk("rw_rsp_valid", 64'(rsp_valid), 64'(0));
    rst = 1'b1;
    slave_word = 32'h0F0F_1234; dly = 1;
    #1;
    chk("rw_rr_zero", 64'(req_ready), 64'(4'b0001));
    @(negedge clk);
    req_valid = '0;
    wait_rsp(got);
    if (got) begin
      chk("rw_post_rsp_valid", 64'(rsp_valid), 64'(4'b0001));
      chk("rw_post_rsp_data", 64'(rsp_data), 64'(32'h0F0F_1234));
      chk("rw_post_err", 64'(rsp_err), 64'(0));
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
